// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit path (and a future receiver).
package uart_pkg;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        EVEN = 2'd1,
        ODD  = 2'd2
    } parity_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tx_state_e;

    // Clock cycles occupied by one complete frame on the line.
    function automatic int frame_clks(input int data_bits, input int clks_per_bit,
                                      input int parity, input int stop_bits);
        return (1 + data_bits + ((parity != 0) ? 1 : 0) + stop_bits) * clks_per_bit;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with registered occupancy; full/empty come straight from the count.
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    // Full is judged on the pre-edge count, so a push while full is dropped even if a pop happens.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (count == DEPTH_CNT);
    assign empty   = (count == '0);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: words queue in a small FIFO and go out as back-to-back frames.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [DATA_BITS-1:0] data,
    output logic                 tx_busy,
    output logic                 tx_done,
    output logic                 tx,
    output logic                 fifo_full,
    output logic                 overflow
);

    localparam int CNT_W = $clog2((DATA_BITS > STOP_BITS) ? DATA_BITS : STOP_BITS);
    localparam int TMR_W = $clog2(CLKS_PER_BIT);
    localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_BITS - 1);
    localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_BITS - 1);
    localparam bit HAS_PARITY = (PARITY != int'(NONE));
    localparam bit ODD_PARITY = (PARITY == int'(ODD));

    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_tx_fifo: DATA_BITS must be 5..9");
    end
    if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
        $error("uart_tx_fifo: CLKS_PER_BIT must be at least 2");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
        $error("uart_tx_fifo: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
        $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_tx_fifo: FIFO_DEPTH must be a power of two, at least 2");
    end

    tx_state_e            state;
    tx_state_e            state_next;
    logic [TMR_W-1:0]     timer;
    logic [TMR_W-1:0]     timer_next;
    logic [CNT_W-1:0]     bit_cnt;
    logic [CNT_W-1:0]     bit_cnt_next;
    logic [DATA_BITS-1:0] shift_reg;
    logic [DATA_BITS-1:0] shift_next;
    logic                 parity_bit;
    logic                 parity_next;
    logic                 tx_next;
    logic                 done_next;
    logic                 bit_end;
    logic                 fifo_pop;
    logic                 fifo_empty;
    logic [DATA_BITS-1:0] fifo_rdata;

    uart_sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (start),
        .pop   (fifo_pop),
        .wdata (data),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign bit_end = (timer == TMR_LAST);
    assign tx_busy = (state != ST_IDLE);

    // Next-state logic; the line level is derived from the next state so tx can be a register.
    always_comb begin
        state_next   = state;
        timer_next   = timer;
        bit_cnt_next = bit_cnt;
        shift_next   = shift_reg;
        parity_next  = parity_bit;
        fifo_pop     = 1'b0;
        done_next    = 1'b0;

        if (state != ST_IDLE) begin
            timer_next = bit_end ? '0 : timer + 1'b1;
        end

        case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop    = 1'b1;
                    shift_next  = fifo_rdata;
                    parity_next = (^fifo_rdata) ^ ODD_PARITY;
                    timer_next  = '0;
                    state_next  = ST_START;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    bit_cnt_next = '0;
                    state_next   = ST_DATA;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    if (bit_cnt == DATA_LAST) begin
                        bit_cnt_next = '0;
                        state_next   = HAS_PARITY ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_cnt_next = bit_cnt + 1'b1;
                        shift_next   = shift_reg >> 1;
                    end
                end
            end
            ST_PARITY: begin
                if (bit_end) begin
                    bit_cnt_next = '0;
                    state_next   = ST_STOP;
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    if (bit_cnt == STOP_LAST) begin
                        done_next = 1'b1;
                        // Chain straight into the next start bit when more words are waiting.
                        if (!fifo_empty) begin
                            fifo_pop    = 1'b1;
                            shift_next  = fifo_rdata;
                            parity_next = (^fifo_rdata) ^ ODD_PARITY;
                            state_next  = ST_START;
                        end else begin
                            state_next = ST_IDLE;
                        end
                    end else begin
                        bit_cnt_next = bit_cnt + 1'b1;
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        case (state_next)
            ST_START:  tx_next = 1'b0;
            ST_DATA:   tx_next = shift_next[0];
            ST_PARITY: tx_next = parity_next;
            default:   tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            timer      <= '0;
            bit_cnt    <= '0;
            shift_reg  <= '0;
            parity_bit <= 1'b0;
            tx         <= 1'b1;
            tx_done    <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            state      <= state_next;
            timer      <= timer_next;
            bit_cnt    <= bit_cnt_next;
            shift_reg  <= shift_next;
            parity_bit <= parity_next;
            tx         <= tx_next;
            tx_done    <= done_next;
            overflow   <= start && fifo_full;
        end
    end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Parametrised UART transmitter with a small input FIFO, configurable data width, parity and stop bits. It generalises the fixed 8N1 transmitter: host logic pushes words with a single-cycle strobe and frames are serialised back-to-back with no idle gap. It sits between on-chip producers and the serial `tx` pin, in the same clock domain as the producer.

## Interface
- `DATA_BITS`, default 8: payload bits per frame, legal range 5–9.
- `CLKS_PER_BIT`, default 16: clock cycles per serial bit, at least 2.
- `PARITY`, default 0: 0 = none, 1 = even, 2 = odd.
- `STOP_BITS`, default 1: number of stop bits, 1 or 2.
- `FIFO_DEPTH`, default 4: word capacity, a power of two, at least 2.
- `clk`, in, 1: the single clock; all logic is rising-edge.
- `reset`, in, 1: asynchronous, active-high reset.
- `start`, in, 1: write strobe. Each cycle it is high pushes `data` into the FIFO.
- `data`, in, DATA_BITS: payload, sampled when `start` is high.
- `tx_busy`, out, 1: high whenever the FSM is not IDLE.
- `tx_done`, out, 1: one-cycle pulse per completed frame.
- `tx`, out, 1: serial line, idles high, registered.
- `fifo_full`, out, 1: FIFO holds FIFO_DEPTH words.
- `overflow`, out, 1: one-cycle pulse when `start` is high while `fifo_full` is high; that word is dropped.

## Operation
- Reset (asynchronous, immediate) forces `tx`=1, `tx_busy`=0, `tx_done`=0, `fifo_full`=0 and `overflow`=0. It empties the FIFO and sends the FSM to IDLE.
- Reset mid-frame aborts the frame: `tx` returns high immediately and no `tx_done` is produced.
- FSM states are IDLE, START, DATA, PARITY, STOP.
  - IDLE → START when the FIFO is non-empty. On that transition the head word is popped into the shift register.
  - START → DATA after 1 bit time.
  - DATA lasts DATA_BITS bit times and sends data LSB first.
  - DATA → PARITY if PARITY≠0, otherwise DATA → STOP.
  - PARITY lasts 1 bit time, then goes to STOP.
  - STOP lasts STOP_BITS bit times, then goes to START if the FIFO is non-empty (popping the next word), otherwise to IDLE.
- Line levels: start bit = 0, stop bits = 1.
- Parity bit:
  - even parity: parity bit = XOR of the payload bits;
  - odd parity: parity bit = inverted XOR of the payload bits.
- Bit timer: counts 0..CLKS_PER_BIT-1 and wraps; a bit boundary occurs at the wrap.
- Bit counter: width is clog2(max(DATA_BITS, STOP_BITS)).
- FIFO:
  - a push when full is rejected and raises `overflow`;
  - a simultaneous push and pop when full is also rejected, because full is evaluated before the pop;
  - a simultaneous push and pop when neither full nor empty keeps the count unchanged.
- `data` is captured at push time. Later changes to `data` do not affect queued words.

## Timing
- Frame length F = (1 + DATA_BITS + (PARITY≠0) + STOP_BITS) × CLKS_PER_BIT cycles.
- Latency: when `start` is sampled at edge E0 with the FIFO empty and the FSM in IDLE, `tx` falls at E1 and `tx_busy` rises at E1.
- `tx_done` is high for the single cycle following the edge that ends the last stop bit.
- Back-to-back frames: the next start bit begins at that same edge, so `tx_busy` stays high with zero idle cycles between frames.
- `fifo_full` and `overflow` are registered and update at the edge after the push.

## Structure
- Package `uart_pkg` holds:
  - the `parity_e` enum (NONE, EVEN, ODD);
  - the `tx_state_e` enum;
  - a helper function for frame length.
- Sub-module `uart_sync_fifo` is a synchronous FIFO with parameters WIDTH and DEPTH and ports push, pop, wdata, rdata, full and empty. It is reusable by a future receiver.
- Everything else (FSM, bit timer, shifter, parity) lives in the top level.

## Test plan
- **8N1 single frame.** With CLKS_PER_BIT=4, push 8'hA5 once. Each bit lasts 4 cycles and `tx` must show 0,1,0,1,0,0,1,0,1,1. `tx_done` pulses exactly once, 40 cycles after `tx` falls.
- **Back-to-back frames.** Push 8'h00 and 8'hFF on consecutive cycles. Two 40-cycle frames must occur with no high gap between the stop bit and the next start bit. `tx_busy` stays high for 80 cycles, with 2 `tx_done` pulses 40 cycles apart.
- **Odd parity, 2 stop bits, DATA_BITS=7.** Push 7'h03. The parity bit must be 1 and the frame must be 11 bit times, ending with two high stop bits.
- **Overflow.** With FIFO_DEPTH=4, hold `start` high for 10 cycles with 8'hFF (one word dequeues at E1). `fifo_full` must assert, `overflow` must pulse on each rejected cycle, and exactly 5 frames must be transmitted.
- **Reset mid-frame.** Assert `reset` during DATA for 1 cycle. `tx` must return to 1 immediately, with no `tx_done`. `tx_busy` must be 0 and the FIFO empty; a subsequent push transmits normally.
